boot_bus_sequencer: RTL and testbench
=====================================

BOOT_BUS_SEQUENCER -- requirements
Module: boot_bus_sequencer

Interface
REQ-001 Parameter HANDOFF_CYCLES, default 4: idle bus cycles between copier release and CPU bus enable.
REQ-002 Parameter CPU_RESET_CYCLES, default 8: cycles cpu_reset_n is held low after CPU bus enable.
REQ-003 Parameter COPY_TIMEOUT, default 262144: maximum cycles allowed in COPY before error.
REQ-004 Parameter SHADOW_WP, default 1: when 1, CPU writes to the shadow region do not select RAM.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  system clock, nominally 1 MHz.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 copy_done  in  1  level from the memory copier; high once the EEPROM-to-RAM copy is complete.
REQ-009 cpu_address  in  16  CPU address bus.
REQ-010 cpu_rwb  in  1  CPU read/write; 1 = read.
REQ-011 copy_start  out  1  single-cycle pulse that starts the copier.
REQ-012 copier_bus_en  out  1  copier owns the address bus and the RAM/EEPROM strobes.
REQ-013 cpu_be  out  1  CPU bus enable; CPU drives the address and R/W lines.
REQ-014 cpu_reset_n  out  1  CPU reset, active low.
REQ-015 ram_cs_n, eeprom_cs_n, via_ce_n, acia_ce_n  out  1 each  CPU-side chip selects, active low.
REQ-016 boot_error  out  1  sticky copy-timeout flag.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, START, COPY, HANDOFF, RELEASE, RUN, ERROR.
REQ-018 IDLE SHALL last one cycle, then go to START.
REQ-019 START SHALL assert copy_start for exactly one cycle, then go to COPY.
REQ-020 copier_bus_en SHALL be 1 in START and COPY only.
REQ-021 COPY SHALL go to HANDOFF on the first cycle copy_done is sampled high, including the first COPY cycle.
REQ-022 copy_done SHALL be ignored in every state other than COPY.
REQ-023 COPY SHALL go to ERROR when COPY_TIMEOUT cycles elapse with copy_done low; if done and timeout occur in the same cycle, done wins.
REQ-024 In HANDOFF, copier_bus_en and cpu_be SHALL both be 0 for exactly HANDOFF_CYCLES cycles, then go to RELEASE.
REQ-025 In RELEASE, cpu_be SHALL be 1 and cpu_reset_n SHALL be 0 for exactly CPU_RESET_CYCLES cycles, then go to RUN.
REQ-026 In RUN, cpu_be = 1 and cpu_reset_n = 1; the block stays in RUN until reset.
REQ-027 In ERROR, boot_error = 1, cpu_be = 0, cpu_reset_n = 0, and all chip selects are high; the block stays in ERROR until reset.
REQ-028 Chip selects SHALL be all high outside RUN.
REQ-029 In RUN, chip selects SHALL be a combinational decode of cpu_address and cpu_rwb with zero-cycle latency.
REQ-030 RUN memory map:
- RAM: 0x0000-0xBFFF and 0xE000-0xFFFF (shadow).
- VIA: 0xC000-0xC0FF.
- ACIA: 0xC100-0xC1FF.
- 0xC200-0xDFFF: nothing selected.
REQ-031 eeprom_cs_n SHALL remain high in RUN.
REQ-032 With SHADOW_WP = 1, ram_cs_n SHALL stay high for cpu_rwb = 0 at 0xE000-0xFFFF; reads there select RAM.
REQ-033 At most one chip select SHALL be low in any cycle.
REQ-034 The cycle counter SHALL be wide enough for the largest parameter and SHALL clear on every state entry.
REQ-035 The counter SHALL NOT wrap while in any state.

Reset
REQ-036 While reset is high at a clock edge, the next state SHALL be IDLE and the counter SHALL be 0.
REQ-037 Reset output values: copy_start = 0, copier_bus_en = 0, cpu_be = 0, cpu_reset_n = 0, all chip selects = 1, boot_error = 0.
REQ-038 Reset asserted mid-COPY or mid-RELEASE SHALL abort the sequence; the next copy_start comes only after IDLE -> START.
REQ-039 All outputs except the RUN chip-select decode SHALL be registered.

Structure
REQ-040 A shared bootstrap package SHALL hold:
- the state encoding;
- the memory-map base and limit constants;
- the default timing parameter values.
REQ-041 The decode SHALL be a sub-module named addr_decode: cpu_address, cpu_rwb, enable, wp in; four selects out.
REQ-042 The top level SHALL drive via_ce_n and acia_ce_n from this block, and mux ram/eeprom strobes on copier_bus_en.

Verification
REQ-043 Release reset; copy_done rises 100 cycles after copy_start -> copy_start is high for one cycle (cycle 1 after reset); copier_bus_en falls 1 cycle after done is sampled; cpu_be rises 4 cycles later; cpu_reset_n rises 8 cycles after that.
REQ-044 Hold copy_done low with COPY_TIMEOUT = 16 -> ERROR 16 cycles after COPY entry; boot_error = 1 and stays 1 when copy_done later rises.
REQ-045 In RUN, sweep addresses 0xBFFF, 0xC000, 0xC0FF, 0xC100, 0xC1FF, 0xC200, 0xDFFF, 0xE000 -> selects ram, via, via, acia, acia, none, none, ram.
REQ-046 In RUN with SHADOW_WP = 1: write to 0xF000 -> no select; read of 0xF000 -> ram_cs_n = 0; write to 0x1000 -> ram_cs_n = 0.
REQ-047 Assert reset during RELEASE cycle 3 -> outputs return to reset values on the next edge; a full sequence restarts, with a single copy_start pulse.
REQ-048 copy_done held high from reset -> COPY lasts exactly one cycle; no second copy_start pulse.

Source files
------------

// File: rtl/boot_bus_sequencer_pkg.sv
// Shared bootstrap definitions: FSM encoding, RUN memory map and default timing.
package boot_bus_sequencer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_COPY    = 3'd2;
  localparam logic [2:0] ST_HANDOFF = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_RUN     = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  localparam int DEF_HANDOFF_CYCLES   = 4;
  localparam int DEF_CPU_RESET_CYCLES = 8;
  localparam int DEF_COPY_TIMEOUT     = 262144;

  localparam logic [15:0] RAM_LOW_LIMIT = 16'hBFFF;
  localparam logic [15:0] VIA_BASE      = 16'hC000;
  localparam logic [15:0] VIA_LIMIT     = 16'hC0FF;
  localparam logic [15:0] ACIA_BASE     = 16'hC100;
  localparam logic [15:0] ACIA_LIMIT    = 16'hC1FF;
  localparam logic [15:0] SHADOW_BASE   = 16'hE000;

  // Counter width that holds the largest of the three cycle budgets.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/boot_bus_sequencer_addr_decode.sv
// CPU-side chip-select decode for the RUN memory map; purely combinational.
module addr_decode
  import boot_bus_sequencer_pkg::*;
(
  input  logic [15:0] cpu_address,
  input  logic        cpu_rwb,
  input  logic        enable,
  input  logic        wp,
  output logic        ram_cs_n,
  output logic        eeprom_cs_n,
  output logic        via_cs_n,
  output logic        acia_cs_n
);

  always_comb begin
    ram_cs_n    = 1'b1;
    eeprom_cs_n = 1'b1;
    via_cs_n    = 1'b1;
    acia_cs_n   = 1'b1;
    if (enable) begin
      if (cpu_address <= RAM_LOW_LIMIT) begin
        ram_cs_n = 1'b0;
      end else if (cpu_address >= VIA_BASE && cpu_address <= VIA_LIMIT) begin
        via_cs_n = 1'b0;
      end else if (cpu_address >= ACIA_BASE && cpu_address <= ACIA_LIMIT) begin
        acia_cs_n = 1'b0;
      end else if (cpu_address >= SHADOW_BASE && !(wp && !cpu_rwb)) begin
        // Shadow copy of the boot image: reads always, writes only when unprotected.
        ram_cs_n = 1'b0;
      end
    end
  end

endmodule

// File: rtl/boot_bus_sequencer.sv
// Boot sequencer: starts the EEPROM-to-RAM copier, hands the bus to the CPU,
// releases CPU reset and then decodes CPU chip selects.
module boot_bus_sequencer
  import boot_bus_sequencer_pkg::*;
#(
  parameter int HANDOFF_CYCLES   = DEF_HANDOFF_CYCLES,
  parameter int CPU_RESET_CYCLES = DEF_CPU_RESET_CYCLES,
  parameter int COPY_TIMEOUT     = DEF_COPY_TIMEOUT,
  parameter bit SHADOW_WP        = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        copy_done,
  input  logic [15:0] cpu_address,
  input  logic        cpu_rwb,
  output logic        copy_start,
  output logic        copier_bus_en,
  output logic        cpu_be,
  output logic        cpu_reset_n,
  output logic        ram_cs_n,
  output logic        eeprom_cs_n,
  output logic        via_ce_n,
  output logic        acia_ce_n,
  output logic        boot_error
);

  localparam int CNT_W = cnt_width(HANDOFF_CYCLES, CPU_RESET_CYCLES, COPY_TIMEOUT);
  localparam logic [CNT_W-1:0] COPY_LAST    = CNT_W'(COPY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HANDOFF_LAST = CNT_W'(HANDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(CPU_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             copy_start_reg, copier_bus_en_reg, cpu_be_reg;
  logic             cpu_reset_n_reg, boot_error_reg;
  logic             dec_ram_cs_n, dec_eeprom_cs_n;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    state_next = ST_START;
      ST_START:   state_next = ST_COPY;
      ST_COPY: begin
        if (copy_done)                   state_next = ST_HANDOFF;
        else if (cnt_reg == COPY_LAST)   state_next = ST_ERROR;
      end
      ST_HANDOFF: if (cnt_reg == HANDOFF_LAST) state_next = ST_RELEASE;
      ST_RELEASE: if (cnt_reg == RELEASE_LAST) state_next = ST_RUN;
      ST_RUN:     state_next = ST_RUN;
      ST_ERROR:   state_next = ST_ERROR;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg)  cnt_next = '0;
    else if (cnt_reg != CNT_MAX)  cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      copy_start_reg    <= 1'b0;
      copier_bus_en_reg <= 1'b0;
      cpu_be_reg        <= 1'b0;
      cpu_reset_n_reg   <= 1'b0;
      boot_error_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      copy_start_reg    <= (state_next == ST_START);
      copier_bus_en_reg <= (state_next == ST_START) || (state_next == ST_COPY);
      cpu_be_reg        <= (state_next == ST_RELEASE) || (state_next == ST_RUN);
      cpu_reset_n_reg   <= (state_next == ST_RUN);
      boot_error_reg    <= (state_next == ST_ERROR);
    end
  end

  addr_decode u_addr_decode (
    .cpu_address (cpu_address),
    .cpu_rwb     (cpu_rwb),
    .enable      (state_reg == ST_RUN),
    .wp          (SHADOW_WP),
    .ram_cs_n    (dec_ram_cs_n),
    .eeprom_cs_n (dec_eeprom_cs_n),
    .via_cs_n    (via_ce_n),
    .acia_cs_n   (acia_ce_n)
  );

  // While the copier owns the bus the CPU-side RAM/EEPROM strobes stay inactive.
  assign ram_cs_n      = copier_bus_en_reg ? 1'b1 : dec_ram_cs_n;
  assign eeprom_cs_n   = copier_bus_en_reg ? 1'b1 : dec_eeprom_cs_n;

  assign copy_start    = copy_start_reg;
  assign copier_bus_en = copier_bus_en_reg;
  assign cpu_be        = cpu_be_reg;
  assign cpu_reset_n   = cpu_reset_n_reg;
  assign boot_error    = boot_error_reg;

endmodule

// File: tb/tb_boot_bus_sequencer.sv
// Directed bench for boot_bus_sequencer: boot timing, decode map, reset abort and timeout.
module tb_boot_bus_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        copy_done = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic        cpu_rwb = 1'b1;
  logic        t_reset = 1'b1;
  logic        t_done = 1'b0;

  logic copy_start, copier_bus_en, cpu_be, cpu_reset_n, boot_error;
  logic ram_cs_n, eeprom_cs_n, via_ce_n, acia_ce_n;
  logic t_copy_start, t_copier_bus_en, t_cpu_be, t_cpu_reset_n, t_boot_error;
  logic t_ram_cs_n, t_eeprom_cs_n, t_via_ce_n, t_acia_ce_n;

  logic [4:0] ctl, t_ctl;
  logic [3:0] cs, t_cs;
  assign ctl   = {copy_start, copier_bus_en, cpu_be, cpu_reset_n, boot_error};
  assign cs    = {ram_cs_n, eeprom_cs_n, via_ce_n, acia_ce_n};
  assign t_ctl = {t_copy_start, t_copier_bus_en, t_cpu_be, t_cpu_reset_n, t_boot_error};
  assign t_cs  = {t_ram_cs_n, t_eeprom_cs_n, t_via_ce_n, t_acia_ce_n};

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  boot_bus_sequencer dut (
    .clock (clock), .reset (reset), .copy_done (copy_done),
    .cpu_address (cpu_address), .cpu_rwb (cpu_rwb),
    .copy_start (copy_start), .copier_bus_en (copier_bus_en), .cpu_be (cpu_be),
    .cpu_reset_n (cpu_reset_n), .ram_cs_n (ram_cs_n), .eeprom_cs_n (eeprom_cs_n),
    .via_ce_n (via_ce_n), .acia_ce_n (acia_ce_n), .boot_error (boot_error)
  );

  boot_bus_sequencer #(.COPY_TIMEOUT(16)) dut_to (
    .clock (clock), .reset (t_reset), .copy_done (t_done),
    .cpu_address (cpu_address), .cpu_rwb (cpu_rwb),
    .copy_start (t_copy_start), .copier_bus_en (t_copier_bus_en), .cpu_be (t_cpu_be),
    .cpu_reset_n (t_cpu_reset_n), .ram_cs_n (t_ram_cs_n), .eeprom_cs_n (t_eeprom_cs_n),
    .via_ce_n (t_via_ce_n), .acia_ce_n (t_acia_ce_n), .boot_error (t_boot_error)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    copy_done = 1'b0;
    repeat (3) step();
    checks++;
    if ({ctl, cs} !== 9'b00000_1111) begin
      errors++;
      $display("FAIL reset_values: got ctl=%b cs=%b, want ctl=00000 cs=1111", ctl, cs);
    end
    $display("reset: ctl=%b cs=%b", ctl, cs);
  endtask

  task automatic test_boot_sequence;
    int pulses;
    int k;
    reset = 1'b0;
    step();
    checks++;
    if ({ctl, cs} !== 9'b11000_1111) begin
      errors++;
      $display("FAIL start_cycle: got ctl=%b cs=%b, want ctl=11000 cs=1111", ctl, cs);
    end
    step();
    checks++;
    if ({ctl, cs} !== 9'b01000_1111) begin
      errors++;
      $display("FAIL copy_entry: got ctl=%b cs=%b, want ctl=01000 cs=1111", ctl, cs);
    end
    pulses = 0;
    repeat (99) begin
      step();
      if (copy_start) pulses++;
    end
    checks++;
    if (pulses !== 0 || copier_bus_en !== 1'b1) begin
      errors++;
      $display("FAIL copy_hold: got extra_pulses=%0d bus_en=%b, want 0 and 1", pulses, copier_bus_en);
    end
    copy_done = 1'b1;
    step();
    checks++;
    if (ctl !== 5'b00000) begin
      errors++;
      $display("FAIL handoff_entry: got ctl=%b, want 00000", ctl);
    end
    k = 0;
    while (!cpu_be && k < 50) begin step(); k++; end
    checks++;
    if (k !== 4 || ctl !== 5'b00100) begin
      errors++;
      $display("FAIL handoff_len: got %0d cycles ctl=%b, want 4 cycles ctl=00100", k, ctl);
    end
    k = 0;
    while (!cpu_reset_n && k < 50) begin step(); k++; end
    checks++;
    if (k !== 8 || ctl !== 5'b00110) begin
      errors++;
      $display("FAIL release_len: got %0d cycles ctl=%b, want 8 cycles ctl=00110", k, ctl);
    end
    $display("boot: handoff/release done, ctl=%b", ctl);
  endtask

  task automatic test_decode_sweep;
    logic [15:0] addrs [10];
    logic [3:0]  exps  [10];
    logic        rws   [10];
    addrs = '{16'hBFFF, 16'hC000, 16'hC0FF, 16'hC100, 16'hC1FF,
              16'hC200, 16'hDFFF, 16'hE000, 16'h0000, 16'hC080};
    exps  = '{4'b0111, 4'b1101, 4'b1101, 4'b1110, 4'b1110,
              4'b1111, 4'b1111, 4'b0111, 4'b0111, 4'b1101};
    rws   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step();
      cpu_address = addrs[i];
      cpu_rwb = rws[i];
      #1;
      checks++;
      if (cs !== exps[i]) begin
        errors++;
        $display("FAIL decode_%h: got cs=%b, want %b", addrs[i], cs, exps[i]);
      end
      $display("decode: addr=%h rwb=%b cs=%b", cpu_address, cpu_rwb, cs);
    end
  endtask

  task automatic test_shadow_wp;
    logic [15:0] addrs [4];
    logic        rws   [4];
    logic [3:0]  exps  [4];
    addrs = '{16'hF000, 16'hF000, 16'h1000, 16'hFFFF};
    rws   = '{1'b0, 1'b1, 1'b0, 1'b0};
    exps  = '{4'b1111, 4'b0111, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      step();
      cpu_address = addrs[i];
      cpu_rwb = rws[i];
      #1;
      checks++;
      if (cs !== exps[i]) begin
        errors++;
        $display("FAIL shadow_%h_rwb%b: got cs=%b, want %b", addrs[i], rws[i], cs, exps[i]);
      end
      $display("shadow: addr=%h rwb=%b cs=%b", cpu_address, cpu_rwb, cs);
    end
    cpu_address = 16'h0000;
    cpu_rwb = 1'b1;
  endtask

  task automatic test_reset_in_release;
    int k;
    int pulses;
    reset = 1'b1;
    copy_done = 1'b1;
    step();
    reset = 1'b0;
    k = 0;
    while (!cpu_be && k < 50) begin step(); k++; end
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({ctl, cs} !== 9'b00000_1111) begin
      errors++;
      $display("FAIL release_abort: got ctl=%b cs=%b, want ctl=00000 cs=1111", ctl, cs);
    end
    reset = 1'b0;
    k = 0;
    pulses = 0;
    while (!cpu_reset_n && k < 100) begin
      step();
      k++;
      if (copy_start) pulses++;
    end
    checks++;
    if (pulses !== 1 || k !== 15) begin
      errors++;
      $display("FAIL restart_seq: got pulses=%0d cycles=%0d, want 1 and 15", pulses, k);
    end
    $display("reset_in_release: restart pulses=%0d cycles=%0d", pulses, k);
  endtask

  task automatic test_done_early;
    int k;
    int pulses;
    reset = 1'b1;
    copy_done = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (ctl !== 5'b01000) begin
      errors++;
      $display("FAIL early_copy: got ctl=%b, want 01000", ctl);
    end
    step();
    checks++;
    if (ctl !== 5'b00000) begin
      errors++;
      $display("FAIL early_handoff: got ctl=%b, want 00000", ctl);
    end
    k = 0;
    pulses = 0;
    while (!cpu_reset_n && k < 50) begin
      step();
      k++;
      if (copy_start) pulses++;
    end
    checks++;
    if (pulses !== 0 || cpu_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL early_no_repulse: got pulses=%0d reset_n=%b, want 0 and 1", pulses, cpu_reset_n);
    end
    $display("done_early: extra pulses=%0d", pulses);
  endtask

  task automatic test_timeout;
    int bad;
    t_reset = 1'b1;
    t_done = 1'b0;
    step();
    t_reset = 1'b0;
    step();
    step();
    checks++;
    if (t_ctl !== 5'b01000) begin
      errors++;
      $display("FAIL timeout_copy_entry: got ctl=%b, want 01000", t_ctl);
    end
    bad = 0;
    repeat (15) begin
      step();
      if (!t_copier_bus_en || t_boot_error) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d early-exit cycles, want 0", bad);
    end
    step();
    checks++;
    if ({t_ctl, t_cs} !== 9'b00001_1111) begin
      errors++;
      $display("FAIL timeout_error: got ctl=%b cs=%b, want ctl=00001 cs=1111", t_ctl, t_cs);
    end
    t_done = 1'b1;
    repeat (5) step();
    checks++;
    if ({t_ctl, t_cs} !== 9'b00001_1111) begin
      errors++;
      $display("FAIL error_sticky: got ctl=%b cs=%b, want ctl=00001 cs=1111", t_ctl, t_cs);
    end
    $display("timeout: ctl=%b cs=%b", t_ctl, t_cs);
  endtask

  initial begin
    test_reset();
    test_boot_sequence();
    test_decode_sweep();
    test_shadow_wp();
    test_reset_in_release();
    test_done_early();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
